// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with write-to-read bypass, per-register pending bits
// and a post-reset sweep that zeroes every register before ready rises.
module regfile_scoreboard #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD = 2,
   parameter int ZERO_REG = 1,
   localparam int AW = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   input  logic [NRD*AW-1:0] rs,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]    rbusy,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   input  logic              flush
);
   typedef enum logic {INIT, RUN} stateT;
   stateT state;
   logic [AW-1:0] cnt;
   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy, busyNext;
   logic writeOk, rsvOk;
   assign writeOk = we && state == RUN && !(ZERO_REG != 0 && waddr == '0);
   assign rsvOk = rsv_en && state == RUN && !(ZERO_REG != 0 && rsv_addr == '0);
   // reserve beats write beats flush on the same bit
   always_comb begin
      busyNext = flush ? '0 : busy;
      if (writeOk) busyNext[waddr] = 1'b0;
      if (rsvOk) busyNext[rsv_addr] = 1'b1;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= INIT;
         cnt <= '0;
         busy <= '0;
         ready <= 1'b0;
      end else if (state == INIT) begin
         cnt <= cnt + AW'(1);
         if (cnt == AW'(NREG - 1)) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end else
         busy <= busyNext;
   always_ff @(posedge clk)
      if (!rst) begin
         if (state == INIT) regs[cnt] <= '0;
         else if (writeOk) regs[waddr] <= wdata;
      end
   for (genvar p = 0; p < NRD; p++) begin : gRd
      logic [AW-1:0] a;
      logic isZero, isByp;
      assign a = rs[p*AW +: AW];
      assign isZero = ZERO_REG != 0 && a == '0;
      assign isByp = we && waddr == a;
      assign rdata[p*XLEN +: XLEN] = (!ready || isZero) ? '0 : isByp ? wdata : regs[a];
      assign rbusy[p] = (!ready || isZero || isByp) ? 1'b0 : busy[a];
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks on the default configuration plus random traffic
// on a 64-bit, 16-entry, 3-port instance without a hardwired zero register.
module tb_regfile_scoreboard;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, ready, we, rsv_en, flush;
   logic [9:0] rs;
   logic [63:0] rdata;
   logic [1:0] rbusy;
   logic [4:0] waddr, rsv_addr;
   logic [31:0] wdata;

   logic rstB, readyB, weB, rsvEnB, flushB;
   logic [11:0] rsB;
   logic [191:0] rdataB;
   logic [2:0] rbusyB;
   logic [3:0] waddrB, rsvAddrB, a;
   logic [63:0] wdataB;

   logic [63:0] mReg [16];
   logic [15:0] mBusy;
   logic [191:0] expD;
   logic [2:0] expB;
   logic [31:0] bv;
   int n, nChecks, nFail;

   logic [255:0] expQ[$];
   string tagQ[$];

   regfile_scoreboard dut (
      .clk(clk), .rst(rst), .ready(ready), .rs(rs), .rdata(rdata), .rbusy(rbusy),
      .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
   );

   regfile_scoreboard #(.XLEN(64), .NREG(16), .NRD(3), .ZERO_REG(0)) dutB (
      .clk(clk), .rst(rstB), .ready(readyB), .rs(rsB), .rdata(rdataB), .rbusy(rbusyB),
      .we(weB), .waddr(waddrB), .wdata(wdataB), .rsv_en(rsvEnB), .rsv_addr(rsvAddrB), .flush(flushB)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0;
      rsv_en = 1'b0;
      flush = 1'b0;
   endtask

   task automatic push(input string t, input logic [255:0] v);
      expQ.push_back(v);
      tagQ.push_back(t);
   endtask

   task automatic check(input logic [255:0] obs);
      logic [255:0] e;
      string t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      nChecks++;
      assert (obs === e) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
   endtask

   initial begin
      nChecks = 0;
      nFail = 0;
      rst = 1'b1; rs = '0; waddr = '0; wdata = '0; rsv_addr = '0;
      idle();
      rstB = 1'b1; weB = 1'b0; rsvEnB = 1'b0; flushB = 1'b0;
      rsB = '0; waddrB = '0; wdataB = '0; rsvAddrB = '0;
      repeat (3) step();
      #2;
      push("rstReady", 256'(0)); check(256'(ready));
      push("rstRead", 256'(0)); check(256'({rbusy, rdata}));
      push("rstReadyB", 256'(0)); check(256'(readyB));
      push("rstReadB", 256'(0)); check(256'({rbusyB, rdataB}));
      // sweep interrupted by reset at cycle 10
      rst = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      step();
      #2;
      push("midRstReady", 256'(0)); check(256'(ready));
      rst = 1'b0;
      we = 1'b1; waddr = 5'd2; wdata = 32'hAAAA; rsv_en = 1'b1; rsv_addr = 5'd2; flush = 1'b1;
      rs = {5'd2, 5'd2};
      #2;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         if (n == 5) begin
            push("initRead", 256'(0)); check(256'({rbusy, rdata}));
         end
         if (n == 20) idle();
         n++;
         step();
         #2;
      end
      push("sweepLen", 256'(32)); check(256'(n));
      step();
      for (int i = 0; i < 32; i++) begin
         rs = {5'(31 - i), 5'(i)};
         #2;
         push("zeroAfterSweep", 256'(0)); check(256'({rbusy, rdata}));
         step();
      end
      // write with same-cycle bypass
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; rs = {5'd0, 5'd5};
      #2;
      push("bypass", 256'(32'hDEADBEEF)); check(256'(rdata[31:0]));
      step();
      idle();
      #2;
      push("afterWrite", 256'(32'hDEADBEEF)); check(256'(rdata[31:0]));
      step();
      // x0 is hardwired
      we = 1'b1; waddr = 5'd0; wdata = 32'h1234; rsv_en = 1'b1; rsv_addr = 5'd0; rs = '0;
      #2;
      push("zeroSame", 256'(0)); check(256'({rbusy, rdata}));
      step();
      idle();
      #2;
      push("zeroNext", 256'(0)); check(256'({rbusy, rdata}));
      step();
      // scoreboard reserve / write
      rsv_en = 1'b1; rsv_addr = 5'd7; rs = {5'd7, 5'd0};
      #2;
      push("rsvSameCycle", 256'(0)); check(256'(rbusy[1]));
      step();
      idle();
      #2;
      push("rsvBusy", 256'(1)); check(256'(rbusy[1]));
      we = 1'b1; waddr = 5'd7; wdata = 32'h55;
      #2;
      push("writeClearsByp", 256'({1'b0, 32'h55})); check(256'({rbusy[1], rdata[63:32]}));
      step();
      idle();
      #2;
      push("writeClears", 256'({1'b0, 32'h55})); check(256'({rbusy[1], rdata[63:32]}));
      we = 1'b1; waddr = 5'd7; wdata = 32'h77; rsv_en = 1'b1; rsv_addr = 5'd7;
      step();
      idle();
      #2;
      push("rsvBeatsWrite", 256'({1'b1, 32'h77})); check(256'({rbusy[1], rdata[63:32]}));
      // flush with a concurrent reserve
      rsv_en = 1'b1; rsv_addr = 5'd3; step();
      rsv_addr = 5'd4; step();
      rsv_addr = 5'd9; step();
      rsv_addr = 5'd12; flush = 1'b1; step();
      idle();
      bv = '0;
      for (int i = 0; i < 32; i++) begin
         rs = {5'(i), 5'(i)};
         #2;
         bv[i] = rbusy[0] | rbusy[1];
         step();
      end
      push("flushKeepsRsv", 256'(32'h1000)); check(256'(bv));
      // second configuration: 16-cycle sweep then random traffic against a model
      rstB = 1'b0;
      #2;
      n = 0;
      while (readyB !== 1'b1 && n < 100) begin
         n++;
         step();
         #2;
      end
      push("sweepLenB", 256'(16)); check(256'(n));
      for (int i = 0; i < 16; i++) mReg[i] = '0;
      mBusy = '0;
      step();
      for (int c = 0; c < 10000; c++) begin
         weB = 1'($urandom_range(0, 1));
         waddrB = 4'($urandom);
         wdataB = {$urandom, $urandom};
         rsvEnB = ($urandom_range(0, 2) == 0);
         rsvAddrB = 4'($urandom);
         flushB = ($urandom_range(0, 31) == 0);
         for (int p = 0; p < 3; p++) rsB[p*4 +: 4] = 4'($urandom);
         for (int p = 0; p < 3; p++) begin
            a = rsB[p*4 +: 4];
            expD[p*64 +: 64] = (weB && waddrB == a) ? wdataB : mReg[a];
            expB[p] = (weB && waddrB == a) ? 1'b0 : mBusy[a];
         end
         push("random", 256'({expB, expD}));
         #2;
         check(256'({rbusyB, rdataB}));
         if (weB) mReg[waddrB] = wdataB;
         if (flushB) mBusy = '0;
         if (weB) mBusy[waddrB] = 1'b0;
         if (rsvEnB) mBusy[rsvAddrB] = 1'b1;
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
